// File: rtl/alu_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module   : alu_stage_buffer
// Brief    : EX/MEM vector pipeline register with a 2-entry valid/ready skid
//            (main entry M drives the outputs, skid entry S absorbs stalls).
// Revision : 1.0  initial release
// ============================================================================
module alu_stage_buffer #(
    parameter int N     = 20,
    parameter int LANES = 8,
    parameter int RA    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   ALUResult,
    input  logic [LANES*N-1:0]   writeData,
    input  logic [LANES-1:0]     laneMask,
    input  logic [RA-1:0]        WA3,
    input  logic                 RegWrite,
    input  logic                 MemtoReg,
    input  logic                 MemWrite,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   ALUResultO,
    output logic [LANES*N-1:0]   writeDataO,
    output logic [LANES-1:0]     laneMaskO,
    output logic [RA-1:0]        WA3O,
    output logic                 RegWriteO,
    output logic                 MemtoRegO,
    output logic                 MemWriteO
);

    // Bit 0 is M.valid and bit 1 is S.valid, so occupancy reads straight off the state.
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_ONE   = 2'b01;
    localparam logic [1:0] S_TWO   = 2'b11;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   r_in_ready;

    logic                   w_m_valid;
    logic                   w_accept;
    logic                   w_drain;

    logic                   w_m_load_in;
    logic                   w_m_load_s;
    logic                   w_s_load;

    logic [LANES*N-1:0]     r_m_alu;
    logic [LANES*N-1:0]     r_m_wd;
    logic [LANES-1:0]       r_m_mask;
    logic [RA-1:0]          r_m_wa3;
    logic                   r_m_regwrite;
    logic                   r_m_memtoreg;
    logic                   r_m_memwrite;

    logic [LANES*N-1:0]     r_s_alu;
    logic [LANES*N-1:0]     r_s_wd;
    logic [LANES-1:0]       r_s_mask;
    logic [RA-1:0]          r_s_wa3;
    logic                   r_s_regwrite;
    logic                   r_s_memtoreg;
    logic                   r_s_memwrite;

    assign w_m_valid = r_state[0];
    assign w_accept  = in_valid & r_in_ready;
    assign w_drain   = w_m_valid & out_ready;

    // State register; in_ready is registered so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) w_state_nxt = S_ONE;
                end
                S_ONE: begin
                    if (w_drain && !w_accept)      w_state_nxt = S_EMPTY;
                    else if (w_accept && !w_drain) w_state_nxt = S_TWO;
                end
                S_TWO: begin
                    if (w_drain) w_state_nxt = S_ONE;
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Data-register enables; a flushed cycle loads nothing so the discarded input never lands.
    always_comb begin
        w_m_load_in = 1'b0;
        w_m_load_s  = 1'b0;
        w_s_load    = 1'b0;
        if (!flush) begin
            case (r_state)
                S_EMPTY: w_m_load_in = w_accept;
                S_ONE: begin
                    w_m_load_in = w_accept & w_drain;
                    w_s_load    = w_accept & ~w_drain;
                end
                S_TWO:   w_m_load_s  = w_drain;
                default: w_m_load_in = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_alu      <= '0;
            r_m_wd       <= '0;
            r_m_mask     <= '0;
            r_m_wa3      <= '0;
            r_m_regwrite <= 1'b0;
            r_m_memtoreg <= 1'b0;
            r_m_memwrite <= 1'b0;
        end else if (w_m_load_in) begin
            r_m_alu      <= ALUResult;
            r_m_wd       <= writeData;
            r_m_mask     <= laneMask;
            r_m_wa3      <= WA3;
            r_m_regwrite <= RegWrite;
            r_m_memtoreg <= MemtoReg;
            r_m_memwrite <= MemWrite;
        end else if (w_m_load_s) begin
            r_m_alu      <= r_s_alu;
            r_m_wd       <= r_s_wd;
            r_m_mask     <= r_s_mask;
            r_m_wa3      <= r_s_wa3;
            r_m_regwrite <= r_s_regwrite;
            r_m_memtoreg <= r_s_memtoreg;
            r_m_memwrite <= r_s_memwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_alu      <= '0;
            r_s_wd       <= '0;
            r_s_mask     <= '0;
            r_s_wa3      <= '0;
            r_s_regwrite <= 1'b0;
            r_s_memtoreg <= 1'b0;
            r_s_memwrite <= 1'b0;
        end else if (w_s_load) begin
            r_s_alu      <= ALUResult;
            r_s_wd       <= writeData;
            r_s_mask     <= laneMask;
            r_s_wa3      <= WA3;
            r_s_regwrite <= RegWrite;
            r_s_memtoreg <= MemtoReg;
            r_s_memwrite <= MemWrite;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = w_m_valid;
    assign ALUResultO = r_m_alu;
    assign writeDataO = r_m_wd;
    assign WA3O       = r_m_wa3;

    // A bubble must never write, so every enable-like field is qualified by M.valid.
    assign RegWriteO  = r_m_regwrite & w_m_valid;
    assign MemtoRegO  = r_m_memtoreg & w_m_valid;
    assign MemWriteO  = r_m_memwrite & w_m_valid;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_mask
        assign laneMaskO[gi] = r_m_mask[gi] & w_m_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_stage_buffer
// Brief    : Scoreboard bench driving three geometries of alu_stage_buffer
//            (8x20, 4x32, 16x8) with shared handshake and lane-patterned data.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_stage_buffer;

    typedef struct {
        logic [31:0] base;
        logic        step;
        logic [15:0] mask;
        logic [3:0]  wa3;
        logic [2:0]  ctl;   // {RegWrite, MemtoReg, MemWrite}
    } item_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    item_t cur = '{32'h0, 1'b0, 16'h0, 4'h0, 3'b000};

    int checks = 0;
    int errors = 0;
    item_t sb[$];

    always #5 clk = ~clk;

    // Lane i carries base+i (or base when step=0); store data is the same XOR a fixed pattern.
    function automatic logic [511:0] pack(input logic [31:0] base, input logic step,
                                          input int lanes, input int n, input logic wd);
        logic [511:0] r;
        logic [31:0]  v;
        r = '0;
        for (int i = 0; i < lanes; i++) begin
            v = base + (step ? 32'(i) : 32'd0);
            if (wd) v = v ^ 32'h5A5A_A5A5;
            for (int b = 0; b < n; b++) r[i*n+b] = v[b];
        end
        return r;
    endfunction

    logic [511:0] pa0, pw0, pa1, pw1, pa2, pw2;
    assign pa0 = pack(cur.base, cur.step, 8, 20, 1'b0);
    assign pw0 = pack(cur.base, cur.step, 8, 20, 1'b1);
    assign pa1 = pack(cur.base, cur.step, 4, 32, 1'b0);
    assign pw1 = pack(cur.base, cur.step, 4, 32, 1'b1);
    assign pa2 = pack(cur.base, cur.step, 16, 8, 1'b0);
    assign pw2 = pack(cur.base, cur.step, 16, 8, 1'b1);

    logic         rdy0, rdy1, rdy2, vld0, vld1, vld2;
    logic [159:0] alu0, wd0;
    logic [127:0] alu1, wd1, alu2, wd2;
    logic [7:0]   m0;
    logic [3:0]   m1;
    logic [15:0]  m2;
    logic [3:0]   wa0, wa1, wa2;
    logic [2:0]   c0, c1, c2;

    alu_stage_buffer #(.N(20), .LANES(8), .RA(4)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .ALUResult(pa0[159:0]), .writeData(pw0[159:0]), .laneMask(cur.mask[7:0]), .WA3(cur.wa3),
        .RegWrite(cur.ctl[2]), .MemtoReg(cur.ctl[1]), .MemWrite(cur.ctl[0]),
        .out_valid(vld0), .out_ready(out_ready), .ALUResultO(alu0), .writeDataO(wd0),
        .laneMaskO(m0), .WA3O(wa0), .RegWriteO(c0[2]), .MemtoRegO(c0[1]), .MemWriteO(c0[0]));

    alu_stage_buffer #(.N(32), .LANES(4), .RA(4)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .ALUResult(pa1[127:0]), .writeData(pw1[127:0]), .laneMask(cur.mask[3:0]), .WA3(cur.wa3),
        .RegWrite(cur.ctl[2]), .MemtoReg(cur.ctl[1]), .MemWrite(cur.ctl[0]),
        .out_valid(vld1), .out_ready(out_ready), .ALUResultO(alu1), .writeDataO(wd1),
        .laneMaskO(m1), .WA3O(wa1), .RegWriteO(c1[2]), .MemtoRegO(c1[1]), .MemWriteO(c1[0]));

    alu_stage_buffer #(.N(8), .LANES(16), .RA(4)) u_dut2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
        .ALUResult(pa2[127:0]), .writeData(pw2[127:0]), .laneMask(cur.mask), .WA3(cur.wa3),
        .RegWrite(cur.ctl[2]), .MemtoReg(cur.ctl[1]), .MemWrite(cur.ctl[0]),
        .out_valid(vld2), .out_ready(out_ready), .ALUResultO(alu2), .writeDataO(wd2),
        .laneMaskO(m2), .WA3O(wa2), .RegWriteO(c2[2]), .MemtoRegO(c2[1]), .MemWriteO(c2[0]));

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_item(input logic [31:0] base, input logic step, input logic [15:0] mask,
                            input logic [3:0] wa3, input logic [2:0] ctl);
        cur.base = base;
        cur.step = step;
        cur.mask = mask;
        cur.wa3  = wa3;
        cur.ctl  = ctl;
    endtask

    // Monitor: pop on drain, check bubble gating, then record this cycle's accept.
    always @(negedge clk) begin
        item_t e;
        if (vld0 === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {31'd0, vld0}, 512'd0);
            end else begin
                e = sb.pop_front();
                chk("alu_8x20",  alu0, pack(e.base, e.step, 8, 20, 1'b0));
                chk("wd_8x20",   wd0,  pack(e.base, e.step, 8, 20, 1'b1));
                chk("mask_8x20", m0,   e.mask[7:0]);
                chk("wa3_8x20",  wa0,  e.wa3);
                chk("ctl_8x20",  c0,   e.ctl);
                chk("alu_4x32",  alu1, pack(e.base, e.step, 4, 32, 1'b0));
                chk("wd_4x32",   wd1,  pack(e.base, e.step, 4, 32, 1'b1));
                chk("mask_4x32", m1,   e.mask[3:0]);
                chk("alu_16x8",  alu2, pack(e.base, e.step, 16, 8, 1'b0));
                chk("wd_16x8",   wd2,  pack(e.base, e.step, 16, 8, 1'b1));
                chk("mask_16x8", m2,   e.mask);
                chk("ctl_16x8",  c2,   e.ctl);
            end
        end
        if (vld0 === 1'b0) begin
            chk("bubble_gate_8x20",  {c0, m0}, 512'd0);
            chk("bubble_gate_4x32",  {c1, m1}, 512'd0);
            chk("bubble_gate_16x8",  {c2, m2}, 512'd0);
        end
        if (reset || flush) begin
            sb.delete();
        end else if (in_valid && rdy0 === 1'b1) begin
            sb.push_back(cur);
        end
    end

    initial begin
        // Reset state
        repeat (2) cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", vld0, 1'b0);
        chk("rst_in_ready", {rdy2, rdy1, rdy0}, 3'b111);
        chk("rst_alu", alu0, 512'd0);
        chk("rst_wa3", wa0, 4'd0);

        // Streaming A..H at full throughput
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            set_item(32'(k + 1), 1'b1, 16'hFFFF, 4'(k), 3'b100);
            @(negedge clk);
            chk("stream_in_ready", rdy0, 1'b1);
            if (k > 0) chk("stream_out_valid", {vld2, vld1, vld0}, 3'b111);
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_valid", vld0, 1'b1);
        cyc();
        @(negedge clk);
        chk("stream_done_empty", vld0, 1'b0);

        // Fill to TWO under back-pressure, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_item(32'h100, 1'b1, 16'h00FF, 4'h3, 3'b010);
        cyc();
        set_item(32'h200, 1'b1, 16'h5AA5, 4'h5, 3'b001);
        @(negedge clk);
        chk("one_in_ready", rdy0, 1'b1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("two_in_ready", {rdy2, rdy1, rdy0}, 3'b000);
        chk("two_out_valid", vld0, 1'b1);
        cyc();
        @(negedge clk);
        chk("two_hold_wa3", wa0, 4'h3);
        out_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("y_wa3", wa0, 4'h5);
        chk("y_mask", m0, 8'hA5);
        cyc();
        @(negedge clk);
        chk("two_drained_valid", vld0, 1'b0);
        chk("two_drained_ready", rdy0, 1'b1);

        // Flush in ONE with a competing accept
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_item(32'h300, 1'b1, 16'h000F, 4'h7, 3'b001);
        cyc();
        set_item(32'h400, 1'b1, 16'h00F0, 4'h9, 3'b001);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", vld0, 1'b0);
        chk("flush_memwrite", c0[0], 1'b0);
        chk("flush_in_ready", rdy0, 1'b1);
        out_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("flush_not_captured", vld0, 1'b0);

        // Reset while in TWO holding all-ones lanes
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_item(32'hFFFFF, 1'b0, 16'hFFFF, 4'hF, 3'b111);
        cyc();
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_alu", alu0, pack(32'hFFFFF, 1'b0, 8, 20, 1'b0));
        chk("pre_rst_in_ready", rdy0, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_alu_8x20", alu0, 512'd0);
        chk("rst2_wd_8x20", wd0, 512'd0);
        chk("rst2_alu_4x32", alu1, 512'd0);
        chk("rst2_alu_16x8", alu2, 512'd0);
        chk("rst2_ctl_mask_wa3", {c0, m0, wa0}, 512'd0);
        chk("rst2_valid_ready", {vld0, rdy0}, 2'b01);

        // Random handshake traffic
        for (int k = 0; k < 1000; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            set_item($urandom, 1'($urandom_range(0, 1)), 16'($urandom),
                     4'($urandom), 3'($urandom));
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("final_valid", vld0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
